// File: rtl/uart_rr_scheduler_pkg.sv
// Shared types and helpers for the round-robin UART scheduler.
package uart_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    HOLD,
    WAITB,
    RD,
    LAT,
    SEND
  } state_t;

  // Header byte identifies the channel; callers truncate to their byte width.
  function automatic logic [31:0] hdr_byte(input logic [31:0] base, input logic [31:0] id);
    return base + id;
  endfunction

endpackage

// File: rtl/uart_rr_scheduler_if.sv
// Bundle of FIFO-side and uart_tx-side signals shared by the scheduler.
interface uart_rr_scheduler_if #(
  parameter int N     = 4,
  parameter int WIDTH = 8
);
  logic [N-1:0]       i_enable;
  logic [N-1:0]       i_empty;
  logic [N*WIDTH-1:0] i_r_data;
  logic [N-1:0]       o_r_en;
  logic               i_busy;
  logic               o_dv;
  logic [WIDTH-1:0]   o_data;
  logic [N-1:0]       o_grant;
  logic               o_active;

  modport master (
    input  i_enable, i_empty, i_r_data, i_busy,
    output o_r_en, o_dv, o_data, o_grant, o_active
  );

  modport slave (
    output i_enable, i_empty, i_r_data, i_busy,
    input  o_r_en, o_dv, o_data, o_grant, o_active
  );
endinterface

// File: rtl/uart_rr_scheduler_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module rr_pick #(
  parameter int N = 4,
  localparam int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic           valid,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] id
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [IDW-1:0] off;
  logic [IDW:0]   sum;

  always_comb begin
    // Rotating a doubled vector puts channel ptr at bit 0.
    dbl   = {req, req} >> ptr;
    rot   = dbl[N-1:0];
    valid = 1'b0;
    off   = '0;
    for (int j = N - 1; j >= 0; j--) begin
      if (rot[j]) begin
        valid = 1'b1;
        off   = IDW'(j);
      end
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= (IDW+1)'(N)) sum = sum - (IDW+1)'(N);
    id    = sum[IDW-1:0];
    grant = valid ? (N'(1) << id) : '0;
  end

endmodule

// File: rtl/uart_rr_scheduler.sv
// Shares one uart_tx among N FIFOs: per grant a header byte, then up to BURST payload bytes.
module uart_rr_scheduler
  import uart_sched_pkg::*;
#(
  parameter int          N        = 4,
  parameter int          WIDTH    = 8,
  parameter int          BURST    = 16,
  parameter int unsigned HDR_BASE = 32'hF0
) (
  input logic                clk,
  input logic                i_reset,
  uart_rr_scheduler_if.master bus
);

  localparam int IDW = $clog2(N);
  localparam int CW  = $clog2(BURST + 1);

  state_t           state, state_nx;
  logic [IDW-1:0]   ptr, ptr_nx;
  logic [IDW-1:0]   gid, gid_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic [N-1:0]     r_en, r_en_nx;
  logic             dv, dv_nx;
  logic [WIDTH-1:0] data, data_nx;
  logic [N-1:0]     grant, grant_nx;
  logic             active, active_nx;

  logic [N-1:0]     eligible;
  logic             pick_valid;
  logic [N-1:0]     pick_grant;
  logic [IDW-1:0]   pick_id;
  logic [WIDTH-1:0] rd_byte;
  logic             ch_ok;
  logic [IDW:0]     ptr_inc;

  assign eligible = bus.i_enable & ~bus.i_empty;

  rr_pick #(.N(N)) u_pick (
    .req   (eligible),
    .ptr   (ptr),
    .valid (pick_valid),
    .grant (pick_grant),
    .id    (pick_id)
  );

  always_comb begin
    rd_byte = '0;
    for (int k = 0; k < N; k++) begin
      if (gid == IDW'(k)) rd_byte = bus.i_r_data[k*WIDTH +: WIDTH];
    end
    ch_ok   = bus.i_enable[gid] & ~bus.i_empty[gid];
    ptr_inc = {1'b0, gid} + (IDW+1)'(1);
    if (ptr_inc == (IDW+1)'(N)) ptr_inc = '0;
  end

  always_comb begin
    state_nx  = state;
    ptr_nx    = ptr;
    gid_nx    = gid;
    cnt_nx    = cnt;
    r_en_nx   = '0;
    dv_nx     = 1'b0;
    data_nx   = data;
    grant_nx  = grant;
    active_nx = active;
    case (state)
      IDLE: begin
        if (pick_valid && !bus.i_busy) begin
          gid_nx    = pick_id;
          data_nx   = WIDTH'(hdr_byte(HDR_BASE, 32'(pick_id)));
          grant_nx  = pick_grant;
          active_nx = 1'b1;
          dv_nx     = 1'b1;
          state_nx  = HDR;
        end
      end
      HDR: begin
        cnt_nx   = '0;
        state_nx = HOLD;
      end
      // uart_tx busy is not yet trustworthy in the cycle after a dv pulse.
      HOLD: state_nx = WAITB;
      WAITB: begin
        if (!bus.i_busy) begin
          if (cnt < CW'(BURST) && ch_ok) begin
            r_en_nx  = grant;
            state_nx = RD;
          end else begin
            ptr_nx    = ptr_inc[IDW-1:0];
            grant_nx  = '0;
            active_nx = 1'b0;
            state_nx  = IDLE;
          end
        end
      end
      RD: state_nx = LAT;
      LAT: begin
        data_nx  = rd_byte;
        cnt_nx   = (cnt == CW'(BURST)) ? cnt : cnt + CW'(1);
        dv_nx    = 1'b1;
        state_nx = SEND;
      end
      SEND:    state_nx = HOLD;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      state  <= IDLE;
      ptr    <= '0;
      cnt    <= '0;
      r_en   <= '0;
      dv     <= 1'b0;
      data   <= '0;
      grant  <= '0;
      active <= 1'b0;
    end else begin
      state  <= state_nx;
      ptr    <= ptr_nx;
      cnt    <= cnt_nx;
      r_en   <= r_en_nx;
      dv     <= dv_nx;
      data   <= data_nx;
      grant  <= grant_nx;
      active <= active_nx;
    end
  end

  // Channel id is only meaningful while a grant is held, so it needs no reset.
  always_ff @(posedge clk) begin
    gid <= gid_nx;
  end

  assign bus.o_r_en   = r_en;
  assign bus.o_dv     = dv;
  assign bus.o_data   = data;
  assign bus.o_grant  = grant;
  assign bus.o_active = active;

endmodule

// File: doc/uart_rr_scheduler.md
# uart_rr_scheduler

Round-robin scheduler that shares one `uart_tx` transmitter between `N` FIFO sources. It sits between per-channel FIFOs (first-word-fall-through not required) and a single `uart_tx`. For each grant it sends a one-byte channel header, then up to `BURST` payload bytes from the granted FIFO. Selection rotates so that no enabled source starves.

## Interface
Parameters:
- `N`, 4, number of source channels (2..16)
- `WIDTH`, 8, data byte width; must match `uart_tx`
- `BURST`, 16, maximum payload bytes per grant (≥1)
- `HDR_BASE`, 8'hF0, header byte = `HDR_BASE + channel_id`, truncated to `WIDTH`

Ports:
- `clk`  in  1  system clock
- `i_reset`  in  1  synchronous, active-high reset
- `i_enable`  in  N  per-channel enable mask
- `i_empty`  in  N  per-channel FIFO empty flags
- `i_r_data`  in  N*WIDTH  FIFO read data; channel k occupies `[k*WIDTH +: WIDTH]`
- `o_r_en`  out  N  per-channel FIFO read strobe, one-hot or zero
- `i_busy`  in  1  `uart_tx` busy
- `o_dv`  out  1  one-cycle data-valid pulse to `uart_tx`
- `o_data`  out  WIDTH  byte to `uart_tx`
- `o_grant`  out  N  one-hot current grant, zero when idle
- `o_active`  out  1  high while any burst is in progress

## Operation
- FIFO contract: read data is valid on the cycle after `o_r_en`.
- `uart_tx` contract: `i_dv` is sampled only when `o_busy`=0, and `o_busy` rises on the next cycle.
- Eligible channel: `i_enable[k] & ~i_empty[k]`.
- Round-robin pointer `ptr` (0 at reset). The search starts at `ptr` and picks the first eligible channel at or after it, wrapping modulo N.
- At burst end, `ptr` ← granted+1, mod N.
- FSM states and transitions:
  - IDLE: if any channel is eligible and `i_busy`=0, latch `gid`, load `o_data`←header, go to HDR.
  - HDR: pulse `o_dv`, go to HOLD. Clear the burst counter.
  - HOLD: one cycle during which `i_busy` is ignored. Go to WAITB.
  - WAITB: wait for `i_busy`=0. Then:
    - go to RD if `cnt<BURST`, `i_enable[gid]`=1 and `i_empty[gid]`=0;
    - otherwise go to IDLE and advance `ptr`.
  - RD: pulse `o_r_en[gid]`, go to LAT.
  - LAT: capture `i_r_data[gid]` into `o_data`, increment `cnt`, go to SEND.
  - SEND: pulse `o_dv`, go to HOLD.
- `o_r_en` is never asserted for a channel whose `i_empty` is high in that same cycle (the RD entry condition guarantees this).
- `cnt` width is `$clog2(BURST+1)`. It saturates at `BURST`.
- Header only (FIFO emptied or channel disabled right after grant): the burst ends after the header byte alone. This is legal, and `ptr` still advances.
- Disabling a channel mid-burst: the byte in flight completes, then the burst ends.
- Reset mid-burst: next edge state=IDLE, `ptr`=0, `cnt`=0, all outputs at reset values. A UART frame already started is not aborted by this block.

## Timing
- Reset values: `o_r_en`=0, `o_dv`=0, `o_data`=0, `o_grant`=0, `o_active`=0.
- All outputs are registered. `o_dv` and each `o_r_en` are high for exactly one cycle per byte.
- Eligible, to header `o_dv`: 2 cycles (IDLE decision edge, HDR).
- `i_busy` falling edge to next `o_r_en`: 1 cycle. `o_r_en` to `o_dv`: 2 cycles (LAT, SEND).
- Back-to-back bytes: per-byte gap = UART frame time + 4 cycles.
- `o_grant`/`o_active` assert on the IDLE→HDR edge and deassert on the WAITB→IDLE edge.
- Minimum of 1 IDLE cycle between bursts.

## Structure
- Package `uart_sched_pkg`: state enum (IDLE, HDR, HOLD, WAITB, RD, LAT, SEND) and the header-byte function `hdr_byte(base, id)`.
- One combinational sub-module, `rr_pick #(N)`:
  - inputs: request vector and `ptr`;
  - outputs: `valid`, one-hot grant and binary id;
  - implemented with a double-width rotate-and-priority-encode.
- FSM, counter and output registers live in the top module.

## Test plan
- Single channel: ch2 holds 3 bytes (11,22,33), BURST=16 → UART sees F2,11,22,33. Exactly 3 `o_r_en[2]` pulses; `ptr` becomes 3.
- Fairness: ch0 and ch1 each hold 40 bytes, BURST=16 → sequence F0+16, F1+16, F0+16, F1+16, F0+8, F1+8.
- Wrap: `ptr`=3, ch3 and ch0 eligible → ch3 is served first, then ch0. `ptr` ends at 1.
- Mid-burst disable: drop `i_enable[1]` during ch1's 2nd payload byte → that byte completes, no further `o_r_en[1]`, next burst goes to the next eligible channel.
- Empty race: ch0 holds 1 byte → F0, byte, end. `o_r_en[0]` never asserts while `i_empty[0]`=1.
- Reset during SEND → next cycle all outputs 0 and state IDLE. After release, arbitration restarts from ch0.
